// File: rtl/ga_result_writeback.sv
// rtl/ga_result_writeback.sv - queues even-ALU multivector results and streams them as 32-bit register-file write beats
// Build option: define GA_WB_ERR_DROP_EN to discard errored results instead of streaming them.

// Even-grade 3D multivector produced by the even ALU: scalar plus three bivector parts, 20-bit fixed point each.
typedef struct packed {
    logic signed [19:0] s;
    logic signed [19:0] e12;
    logic signed [19:0] e23;
    logic signed [19:0] e31;
} ga_multivector_t;

module ga_result_writeback #(
    parameter  int DEPTH     = 2,
    localparam int NUM_WORDS = ($bits(ga_multivector_t) + 31) / 32,
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             res_valid_i,
    input  ga_multivector_t  res_i,
    input  logic             res_error_i,
    output logic             space_o,
    output logic             wr_valid_o,
    input  logic             wr_ready_i,
    output logic [31:0]      wr_data_o,
    output logic [IDX_W-1:0] wr_idx_o,
    output logic             wr_last_o,
    output logic             wr_error_o,
    output logic             overflow_o
);

    localparam int DATA_W = NUM_WORDS * 32;
    localparam int ENT_W  = DATA_W + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 1);

`ifdef GA_WB_ERR_DROP_EN
    localparam bit ERR_DROP = 1'b1;
`else
    localparam bit ERR_DROP = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [IDX_W-1:0] word_q,     word_d;
    logic             overflow_q, overflow_d;

    // Each entry is {error flag, zero-padded result}.
    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] res_pad;
    logic [ENT_W-1:0]  head;
    logic [DATA_W-1:0] head_data;
    logic              head_err;
    logic              sending;
    logic              last_beat;
    logic              beat_acc;
    logic              pop;
    logic              space;
    logic              drop_err;
    logic              push;
    logic              out_en;

    // Next-state logic: pop is resolved before push so a full FIFO can take a result on its final beat.
    always_comb begin
        res_pad                                 = '0;
        res_pad[$bits(ga_multivector_t)-1:0]    = res_i;

        head      = mem_q[rd_ptr_q];
        head_data = head[DATA_W-1:0];
        head_err  = head[DATA_W];

        sending   = (state_q == ST_SEND);
        last_beat = (word_q == LAST_IDX);
        beat_acc  = sending && wr_ready_i;
        pop       = beat_acc && last_beat;
        space     = (count_q < DEPTH_C) || pop;

        // Errored results vanish entirely in the drop build: no enqueue and no overflow.
        drop_err  = ERR_DROP && res_error_i;
        push      = res_valid_i && !drop_err && space;

        overflow_d = overflow_q || (res_valid_i && !drop_err && !space);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        word_d = word_q;
        if (beat_acc) begin
            word_d = last_beat ? '0 : word_q + IDX_W'(1);
        end

        // SEND whenever anything is queued; this also gives back-to-back results with no bubble.
        state_d = (count_d != '0) ? ST_SEND : ST_IDLE;
    end

    // Control state; synchronous active-low reset discards everything queued or in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
        end
    end

    // Result storage; written only on an accepted push, so its contents need no reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem_q[wr_ptr_q] <= {res_error_i, res_pad};
        end
    end

    // Beat outputs come straight from registered state; reset forces them quiet in the same cycle.
    always_comb begin
        out_en     = sending && rst_ni;
        wr_valid_o = out_en;
        wr_data_o  = out_en ? head_data[{word_q, 5'b00000} +: 32] : '0;
        wr_idx_o   = out_en ? word_q : '0;
        wr_last_o  = out_en && last_beat;
        wr_error_o = out_en && !ERR_DROP && head_err;
        space_o    = !rst_ni || space;
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_ga_result_writeback.sv
// tb/tb_ga_result_writeback.sv - self-checking bench for ga_result_writeback (default build)
module tb_ga_result_writeback;

    localparam int DEPTH = 2;
    localparam int RB    = 80;
    localparam int NW    = 3;

    localparam logic [79:0] Z   = 80'h0;
    localparam logic [79:0] R_A = 80'hBEEF_AAAA1111_00000001;
    localparam logic [79:0] R_B = 80'hB2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [79:0] R_C = 80'hC2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [79:0] R_D = 80'hD2D2_D1D1D1D1_D0D0D0D0;
    localparam logic [79:0] R_F = 80'h0F02_0F010F01_0F000F00;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        res_valid_i;
    logic [79:0] res_i;
    logic        res_error_i;
    logic        space_o;
    logic        wr_valid_o;
    logic        wr_ready_i;
    logic [31:0] wr_data_o;
    logic [1:0]  wr_idx_o;
    logic        wr_last_o;
    logic        wr_error_o;
    logic        overflow_o;

    ga_result_writeback #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .res_valid_i (res_valid_i),
        .res_i       (res_i),
        .res_error_i (res_error_i),
        .space_o     (space_o),
        .wr_valid_o  (wr_valid_o),
        .wr_ready_i  (wr_ready_i),
        .wr_data_o   (wr_data_o),
        .wr_idx_o    (wr_idx_o),
        .wr_last_o   (wr_last_o),
        .wr_error_o  (wr_error_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst_n, vld, err, rdy;
        logic [79:0] res;
        logic        e_valid;
        logic [1:0]  e_idx;
        logic        e_last, e_err, e_space, e_ovf;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic [NW*32-1:0] w;
        logic             err;
    } ent_t;

    vec_t vecs[$];
    ent_t mq[$];
    int   widx;
    bit   movf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r, vl, input logic [79:0] d, input logic e, rd,
                               ev, input logic [1:0] ei, input logic el, ee, es, eo,
                               input logic [31:0] ed);
        vec_t x;
        x.rst_n = r; x.vld = vl; x.res = d; x.err = e; x.rdy = rd;
        x.e_valid = ev; x.e_idx = ei; x.e_last = el; x.e_err = ee;
        x.e_space = es; x.e_ovf = eo; x.e_data = ed;
        return x;
    endfunction

    task automatic drive(input logic r, vl, input logic [79:0] d, input logic e, rd);
        rst_ni = r; res_valid_i = vl; res_i = d; res_error_i = e; wr_ready_i = rd;
        #4;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic build_table();
        // single result, reset ignores a strobe
        vecs.push_back(v(0,1,R_A,0,1, 0,0,0,0,1,0,32'h0));
        vecs.push_back(v(1,0,Z  ,0,1, 0,0,0,0,1,0,32'h0));
        vecs.push_back(v(1,1,R_A,0,1, 0,0,0,0,1,0,32'h0));
        vecs.push_back(v(1,0,Z  ,0,1, 1,0,0,0,1,0,32'h00000001));
        vecs.push_back(v(1,0,Z  ,0,1, 1,1,0,0,1,0,32'hAAAA1111));
        vecs.push_back(v(1,0,Z  ,0,1, 1,2,1,0,1,0,32'h0000BEEF));
        vecs.push_back(v(1,0,Z  ,0,1, 0,0,0,0,1,0,32'h0));
        // full FIFO drops C, then A and B back-to-back
        vecs.push_back(v(1,1,R_A,0,0, 0,0,0,0,1,0,32'h0));
        vecs.push_back(v(1,1,R_B,0,0, 1,0,0,0,1,0,32'h00000001));
        vecs.push_back(v(1,1,R_C,0,0, 1,0,0,0,0,0,32'h00000001));
        vecs.push_back(v(1,0,Z  ,0,0, 1,0,0,0,0,1,32'h00000001));
        vecs.push_back(v(1,0,Z  ,0,1, 1,0,0,0,0,1,32'h00000001));
        vecs.push_back(v(1,0,Z  ,0,1, 1,1,0,0,0,1,32'hAAAA1111));
        vecs.push_back(v(1,0,Z  ,0,1, 1,2,1,0,1,1,32'h0000BEEF));
        vecs.push_back(v(1,0,Z  ,0,1, 1,0,0,0,1,1,32'hB0B0B0B0));
        vecs.push_back(v(1,0,Z  ,0,1, 1,1,0,0,1,1,32'hB1B1B1B1));
        vecs.push_back(v(1,0,Z  ,0,1, 1,2,1,0,1,1,32'h0000B2B2));
        vecs.push_back(v(1,0,Z  ,0,1, 0,0,0,0,1,1,32'h0));
        vecs.push_back(v(0,0,Z  ,0,1, 0,0,0,0,1,1,32'h0));
        vecs.push_back(v(1,0,Z  ,0,1, 0,0,0,0,1,0,32'h0));
        // full FIFO, D arrives with A's last beat
        vecs.push_back(v(1,1,R_A,0,0, 0,0,0,0,1,0,32'h0));
        vecs.push_back(v(1,1,R_B,0,0, 1,0,0,0,1,0,32'h00000001));
        vecs.push_back(v(1,0,Z  ,0,1, 1,0,0,0,0,0,32'h00000001));
        vecs.push_back(v(1,0,Z  ,0,1, 1,1,0,0,0,0,32'hAAAA1111));
        vecs.push_back(v(1,1,R_D,0,1, 1,2,1,0,1,0,32'h0000BEEF));
        vecs.push_back(v(1,0,Z  ,0,1, 1,0,0,0,0,0,32'hB0B0B0B0));
        vecs.push_back(v(1,0,Z  ,0,1, 1,1,0,0,0,0,32'hB1B1B1B1));
        vecs.push_back(v(1,0,Z  ,0,1, 1,2,1,0,1,0,32'h0000B2B2));
        vecs.push_back(v(1,0,Z  ,0,1, 1,0,0,0,1,0,32'hD0D0D0D0));
        vecs.push_back(v(1,0,Z  ,0,1, 1,1,0,0,1,0,32'hD1D1D1D1));
        vecs.push_back(v(1,0,Z  ,0,1, 1,2,1,0,1,0,32'h0000D2D2));
        vecs.push_back(v(1,0,Z  ,0,1, 0,0,0,0,1,0,32'h0));
        // errored result streams with the error flag on every beat
        vecs.push_back(v(1,1,R_A,1,1, 0,0,0,0,1,0,32'h0));
        vecs.push_back(v(1,0,Z  ,0,1, 1,0,0,1,1,0,32'h00000001));
        vecs.push_back(v(1,0,Z  ,0,1, 1,1,0,1,1,0,32'hAAAA1111));
        vecs.push_back(v(1,0,Z  ,0,1, 1,2,1,1,1,0,32'h0000BEEF));
        vecs.push_back(v(1,0,Z  ,0,1, 0,0,0,0,1,0,32'h0));
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].vld, vecs[i].res, vecs[i].err, vecs[i].rdy);
            chk($sformatf("vec%0d_valid", i), wr_valid_o, vecs[i].e_valid);
            chk($sformatf("vec%0d_space", i), space_o,    vecs[i].e_space);
            chk($sformatf("vec%0d_ovf",   i), overflow_o, vecs[i].e_ovf);
            if (vecs[i].e_valid || !vecs[i].rst_n) begin
                chk($sformatf("vec%0d_idx",  i), wr_idx_o,   vecs[i].e_idx);
                chk($sformatf("vec%0d_last", i), wr_last_o,  vecs[i].e_last);
                chk($sformatf("vec%0d_err",  i), wr_error_o, vecs[i].e_err);
                chk($sformatf("vec%0d_data", i), wr_data_o,  vecs[i].e_data);
            end
            tick();
        end
    endtask

    task automatic seq_backpressure();
        logic [31:0] got_d[$];
        int          got_i[$];
        bit          rdy_pat[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] exp_d[3]   = '{32'h0F000F00, 32'h0F010F01, 32'h00000F02};
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, c == 0, R_F, 1'b0, rdy_pat[c]);
            if (wr_valid_o && wr_ready_i) begin
                got_d.push_back(wr_data_o);
                got_i.push_back(int'(wr_idx_o));
            end
            if (c >= 2 && c <= 4) begin
                chk("bp_hold_valid", wr_valid_o, 1);
                chk("bp_hold_idx",   wr_idx_o,   1);
                chk("bp_hold_data",  wr_data_o,  32'h0F010F01);
            end
            if (c == 7) chk("bp_idle_after", wr_valid_o, 0);
            tick();
        end
        chk("bp_beat_count", got_d.size(), 3);
        for (int k = 0; k < 3 && k < got_d.size(); k++) begin
            chk($sformatf("bp_beat%0d_data", k), got_d[k], exp_d[k]);
            chk($sformatf("bp_beat%0d_idx",  k), got_i[k], k);
        end
    endtask

    task automatic seq_reset_mid();
        drive(1, 1, R_A, 0, 0); tick();
        drive(1, 1, R_B, 0, 0); tick();
        drive(1, 1, R_C, 0, 0); tick();
        drive(1, 0, Z, 0, 1);
        chk("rm_ovf_set", overflow_o, 1);
        chk("rm_idx0",    wr_idx_o,   0);
        tick();
        drive(1, 0, Z, 0, 1);
        chk("rm_idx1", wr_idx_o, 1);
        tick();
        drive(1, 0, Z, 0, 1);
        chk("rm_idx2", wr_idx_o, 2);
        rst_ni = 1'b0;
        #1;
        chk("rm_rst_valid", wr_valid_o, 0);
        chk("rm_rst_space", space_o,    1);
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(1, 0, Z, 0, 1);
            chk("rm_post_valid", wr_valid_o, 0);
            chk("rm_post_space", space_o,    1);
            chk("rm_post_ovf",   overflow_o, 0);
            tick();
        end
        drive(1, 1, R_D, 0, 1); tick();
        drive(1, 0, Z, 0, 1);
        chk("rm_new_valid", wr_valid_o, 1);
        chk("rm_new_data",  wr_data_o,  32'hD0D0D0D0);
        tick();
        drive(1, 0, Z, 0, 1); tick();
        drive(1, 0, Z, 0, 1); tick();
    endtask

    task automatic run_random(input int cycles);
        drive(0, 0, Z, 0, 0); tick();
        mq.delete(); widx = 0; movf = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            logic        r, vl, e, rd, ev, el, es;
            logic [79:0] d;
            ent_t        ent;
            r  = ($urandom_range(0, 149) != 0);
            vl = ($urandom_range(0, 9) < 4);
            e  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 9) < 7);
            d[31:0]  = $urandom;
            d[63:32] = $urandom;
            d[79:64] = 16'($urandom);
            drive(r, vl, d, e, rd);

            ev = r && (mq.size() > 0);
            el = ev && (widx == NW - 1);
            es = !r || (mq.size() < DEPTH) || (ev && rd && el);
            chk("rnd_valid", wr_valid_o, ev);
            chk("rnd_space", space_o,    es);
            chk("rnd_ovf",   overflow_o, movf);
            if (ev) begin
                chk("rnd_data", wr_data_o,  mq[0].w[widx*32 +: 32]);
                chk("rnd_idx",  wr_idx_o,   widx);
                chk("rnd_last", wr_last_o,  el);
                chk("rnd_err",  wr_error_o, mq[0].err);
            end else if (!r) begin
                chk("rnd_rst_data", wr_data_o, 0);
                chk("rnd_rst_idx",  wr_idx_o,  0);
                chk("rnd_rst_last", wr_last_o, 0);
                chk("rnd_rst_err",  wr_error_o, 0);
            end
            tick();

            if (!r) begin
                mq.delete(); widx = 0; movf = 1'b0;
            end else begin
                if (ev && rd) begin
                    if (el) begin
                        mq.delete(0);
                        widx = 0;
                    end else begin
                        widx++;
                    end
                end
                if (vl) begin
                    if (es) begin
                        ent.w = '0;
                        ent.w[RB-1:0] = d;
                        ent.err = e;
                        mq.push_back(ent);
                    end else begin
                        movf = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; res_valid_i = 1'b0; res_error_i = 1'b0; wr_ready_i = 1'b0; res_i = '0;
        build_table();
        repeat (2) @(posedge clk_i);
        #1;
        run_table();
        seq_backpressure();
        seq_reset_mid();
        run_random(3000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
